// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline: load-use, branch redirect, memory stalls, halt.
// Optional stall-cycle counter on stallCount is built when STALL_CNT_EN is defined.
module pipeline_hazard_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       IDEX_MemRead,
  input  logic [2:0] IDEX_Rd,
  input  logic [2:0] IFID_Rs,
  input  logic [2:0] IFID_Rt,
  input  logic       IFID_ReadingRs,
  input  logic       IFID_ReadingRt,
  input  logic       branchTaken,
  input  logic       IMem_Stall,
  input  logic       IMem_Done,
  input  logic       DMem_Req,
  input  logic       DMem_Stall,
  input  logic       DMem_Done,
  input  logic       MEMWB_Halt,
  output logic       PC_En,
  output logic       IFID_En,
  output logic       IDEX_En,
  output logic       EXMEM_En,
  output logic       MEMWB_En,
  output logic       IFID_Flush,
  output logic       IDEX_Bubble,
  output logic       MEMWB_Bubble,
  output logic       halted
`ifdef STALL_CNT_EN
  ,
  output logic [15:0] stallCount
`endif
);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_DWAIT  = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   squash_pend_q, squash_pend_d;

  logic load_use;
  logic fetch_busy;
  logic data_busy;

  always_comb begin
    load_use   = IDEX_MemRead &
                 ((IFID_ReadingRs & (IFID_Rs == IDEX_Rd)) |
                  (IFID_ReadingRt & (IFID_Rt == IDEX_Rd)));
    // Done in the same cycle as Stall is treated as completion.
    fetch_busy = IMem_Stall & ~IMem_Done;
    data_busy  = DMem_Req & DMem_Stall & ~DMem_Done;
  end

  always_comb begin
    PC_En         = 1'b1;
    IFID_En       = 1'b1;
    IDEX_En       = 1'b1;
    EXMEM_En      = 1'b1;
    MEMWB_En      = 1'b1;
    IFID_Flush    = 1'b0;
    IDEX_Bubble   = 1'b0;
    MEMWB_Bubble  = 1'b0;
    halted        = 1'b0;
    state_d       = state_q;
    squash_pend_d = squash_pend_q;

    if (rst) begin
      PC_En         = 1'b0;
      IFID_En       = 1'b0;
      IDEX_En       = 1'b0;
      EXMEM_En      = 1'b0;
      MEMWB_En      = 1'b0;
      IFID_Flush    = 1'b1;
      IDEX_Bubble   = 1'b1;
      MEMWB_Bubble  = 1'b1;
      state_d       = S_RUN;
      squash_pend_d = 1'b0;
    end else begin
      unique case (state_q)
        S_RUN: begin
          if (MEMWB_Halt) begin
            state_d = S_HALTED;
          end else if (data_busy) begin
            PC_En        = 1'b0;
            IFID_En      = 1'b0;
            IDEX_En      = 1'b0;
            EXMEM_En     = 1'b0;
            MEMWB_Bubble = 1'b1;
            state_d      = S_DWAIT;
          end else begin
            if (branchTaken) begin
              IFID_Flush  = 1'b1;
              IDEX_Bubble = 1'b1;
              if (fetch_busy) squash_pend_d = 1'b1;
            end else if (load_use) begin
              PC_En       = 1'b0;
              IFID_En     = 1'b0;
              IDEX_Bubble = 1'b1;
            end else if (fetch_busy) begin
              PC_En      = 1'b0;
              IFID_Flush = 1'b1;
            end
            // The fetch that was in flight at the redirect returns stale data:
            // discard it and let the redirected PC issue its own fetch.
            if (squash_pend_q && IMem_Done) begin
              PC_En         = 1'b1;
              IFID_Flush    = 1'b1;
              squash_pend_d = 1'b0;
            end
          end
        end
        S_DWAIT: begin
          if (DMem_Done) begin
            state_d = S_RUN;
          end else begin
            PC_En        = 1'b0;
            IFID_En      = 1'b0;
            IDEX_En      = 1'b0;
            EXMEM_En     = 1'b0;
            MEMWB_Bubble = 1'b1;
          end
        end
        S_HALTED: begin
          PC_En    = 1'b0;
          IFID_En  = 1'b0;
          IDEX_En  = 1'b0;
          EXMEM_En = 1'b0;
          MEMWB_En = 1'b0;
          halted   = 1'b1;
        end
        default: begin
          state_d = S_RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    state_q       <= state_d;
    squash_pend_q <= squash_pend_d;
  end

`ifdef STALL_CNT_EN
  logic [15:0] stall_count_q, stall_count_d;

  always_comb begin
    stall_count_d = stall_count_q;
    if (rst) begin
      stall_count_d = '0;
    end else if ((state_q != S_HALTED) && !PC_En) begin
      stall_count_d = stall_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    stall_count_q <= stall_count_d;
  end

  assign stallCount = stall_count_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios plus randomized traffic
// compared each cycle against a rule-level reference model.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       IDEX_MemRead;
  logic [2:0] IDEX_Rd;
  logic [2:0] IFID_Rs;
  logic [2:0] IFID_Rt;
  logic       IFID_ReadingRs;
  logic       IFID_ReadingRt;
  logic       branchTaken;
  logic       IMem_Stall;
  logic       IMem_Done;
  logic       DMem_Req;
  logic       DMem_Stall;
  logic       DMem_Done;
  logic       MEMWB_Halt;
  logic       PC_En, IFID_En, IDEX_En, EXMEM_En, MEMWB_En;
  logic       IFID_Flush, IDEX_Bubble, MEMWB_Bubble, halted;
`ifdef STALL_CNT_EN
  logic [15:0] stallCount;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .IDEX_MemRead   (IDEX_MemRead),
    .IDEX_Rd        (IDEX_Rd),
    .IFID_Rs        (IFID_Rs),
    .IFID_Rt        (IFID_Rt),
    .IFID_ReadingRs (IFID_ReadingRs),
    .IFID_ReadingRt (IFID_ReadingRt),
    .branchTaken    (branchTaken),
    .IMem_Stall     (IMem_Stall),
    .IMem_Done      (IMem_Done),
    .DMem_Req       (DMem_Req),
    .DMem_Stall     (DMem_Stall),
    .DMem_Done      (DMem_Done),
    .MEMWB_Halt     (MEMWB_Halt),
    .PC_En          (PC_En),
    .IFID_En        (IFID_En),
    .IDEX_En        (IDEX_En),
    .EXMEM_En       (EXMEM_En),
    .MEMWB_En       (MEMWB_En),
    .IFID_Flush     (IFID_Flush),
    .IDEX_Bubble    (IDEX_Bubble),
    .MEMWB_Bubble   (MEMWB_Bubble),
    .halted         (halted)
`ifdef STALL_CNT_EN
    ,
    .stallCount     (stallCount)
`endif
  );

  // Reference model: pipeline mode as plain flags plus a counter integer.
  bit m_dwait, m_halted, m_squash;
  int m_cnt;
  bit n_dwait, n_halted, n_squash;
  // Expected {PC,IFID,IDEX,EXMEM,MEMWB enables, IFID_Flush, IDEX_Bubble, MEMWB_Bubble, halted}
  logic [8:0] exp_ctl;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_eval();
    bit en_pc, en_ifid, en_idex, en_exmem, en_memwb, fl, bub, mbub, hlt;
    bit rs_hit, rt_hit, lu, fbusy, dbusy;
    rs_hit = IFID_ReadingRs && (int'(IFID_Rs) == int'(IDEX_Rd));
    rt_hit = IFID_ReadingRt && (int'(IFID_Rt) == int'(IDEX_Rd));
    lu     = IDEX_MemRead && (rs_hit || rt_hit);
    fbusy  = IMem_Stall && !IMem_Done;
    dbusy  = DMem_Req && DMem_Stall && !DMem_Done;
    {en_pc, en_ifid, en_idex, en_exmem, en_memwb} = 5'b11111;
    {fl, bub, mbub, hlt} = 4'b0000;
    n_dwait = m_dwait; n_halted = m_halted; n_squash = m_squash;
    if (rst) begin
      {en_pc, en_ifid, en_idex, en_exmem, en_memwb} = 5'b00000;
      {fl, bub, mbub} = 3'b111;
      n_dwait = 0; n_halted = 0; n_squash = 0;
    end else if (m_halted) begin
      {en_pc, en_ifid, en_idex, en_exmem, en_memwb} = 5'b00000;
      hlt = 1;
    end else if (m_dwait) begin
      if (DMem_Done) n_dwait = 0;
      else begin
        {en_pc, en_ifid, en_idex, en_exmem} = 4'b0000;
        mbub = 1;
      end
    end else if (MEMWB_Halt) begin
      n_halted = 1;
    end else if (dbusy) begin
      {en_pc, en_ifid, en_idex, en_exmem} = 4'b0000;
      mbub = 1;
      n_dwait = 1;
    end else begin
      if (branchTaken) begin
        fl = 1; bub = 1;
        if (fbusy) n_squash = 1;
      end else if (lu) begin
        en_pc = 0; en_ifid = 0; bub = 1;
      end else if (fbusy) begin
        en_pc = 0; fl = 1;
      end
      if (m_squash && IMem_Done) begin
        en_pc = 1; fl = 1; n_squash = 0;
      end
    end
    exp_ctl = {en_pc, en_ifid, en_idex, en_exmem, en_memwb, fl, bub, mbub, hlt};
  endtask

  task automatic model_commit();
    if (rst) m_cnt = 0;
    else if (!m_halted && !exp_ctl[8]) m_cnt = (m_cnt + 1) % 65536;
    m_dwait = n_dwait; m_halted = n_halted; m_squash = n_squash;
  endtask

  // Inputs are already set (just after a rising edge); check combinational outputs, then clock.
  task automatic step();
    #2;
    model_eval();
    chk("ctl", {23'd0, PC_En, IFID_En, IDEX_En, EXMEM_En, MEMWB_En,
                IFID_Flush, IDEX_Bubble, MEMWB_Bubble, halted}, {23'd0, exp_ctl});
    @(posedge clk);
    model_commit();
    #1;
`ifdef STALL_CNT_EN
    chk("stallCount", {16'd0, stallCount}, m_cnt);
`endif
  endtask

  task automatic quiet();
    rst = 0; IDEX_MemRead = 0; IDEX_Rd = 0; IFID_Rs = 0; IFID_Rt = 0;
    IFID_ReadingRs = 0; IFID_ReadingRt = 0; branchTaken = 0;
    IMem_Stall = 0; IMem_Done = 0; DMem_Req = 0; DMem_Stall = 0; DMem_Done = 0;
    MEMWB_Halt = 0;
  endtask

  task automatic do_reset();
    quiet(); rst = 1;
    step(); step();
    rst = 0;
  endtask

  initial begin
    m_dwait = 0; m_halted = 0; m_squash = 0; m_cnt = 0;
    @(posedge clk); #1;
    do_reset();

    // Quiet pipe after reset: all enables, no bubbles.
    quiet(); step();
    chk("run_en", {27'd0, PC_En, IFID_En, IDEX_En, EXMEM_En, MEMWB_En}, 32'h1F);

    // Load-use: ld r3 in EX, add r1,r3,r2 in ID.
    IDEX_MemRead = 1; IDEX_Rd = 3'd3; IFID_Rs = 3'd3; IFID_Rt = 3'd2;
    IFID_ReadingRs = 1; IFID_ReadingRt = 1;
    #2;
    chk("lu_pc", PC_En, 0);
    chk("lu_bub", IDEX_Bubble, 1);
    step();
    IDEX_MemRead = 0; step();
    // Same registers, but ID reads neither: no stall.
    IDEX_MemRead = 1; IFID_ReadingRs = 0; IFID_ReadingRt = 0;
    #2;
    chk("lu_noread", PC_En, 1);
    step();
    quiet(); step();

    // Data stall for 3 busy cycles then Done.
    do_reset();
    DMem_Req = 1; DMem_Stall = 1;
    for (int i = 0; i < 3; i++) begin
      #2;
      chk("ds_exmem", EXMEM_En, 0);
      chk("ds_mbub", MEMWB_Bubble, 1);
      step();
    end
    DMem_Stall = 0; DMem_Done = 1;
    #2;
    chk("ds_done", {27'd0, PC_En, IFID_En, IDEX_En, EXMEM_En, MEMWB_En}, 32'h1F);
    step();
`ifdef STALL_CNT_EN
    chk("ds_cnt3", {16'd0, stallCount}, 3);
`endif
    quiet(); step();

    // Branch during fetch stall, Done two cycles later.
    branchTaken = 1; IMem_Stall = 1;
    #2; chk("br_flush", IFID_Flush, 1);
    step();
    branchTaken = 0; step();
    IMem_Stall = 0; IMem_Done = 1;
    #2; chk("sq_flush", IFID_Flush, 1); chk("sq_pc", PC_En, 1);
    step();
    IMem_Done = 1;
    #2; chk("sq_clear", IFID_Flush, 0);
    step();
    quiet(); step();

    // Branch and load-use together: branch wins.
    branchTaken = 1; IDEX_MemRead = 1; IDEX_Rd = 3'd5; IFID_Rt = 3'd5; IFID_ReadingRt = 1;
    #2; chk("brlu_pc", PC_En, 1); chk("brlu_bub", IDEX_Bubble, 1);
    step();
    quiet(); step();

    // Halt persists until reset.
    MEMWB_Halt = 1; step();
    MEMWB_Halt = 0;
    for (int i = 0; i < 10; i++) begin
      #2; chk("halted", halted, 1);
      step();
    end
    do_reset();
    #2; chk("unhalt", halted, 0);
    step();

    // Reset during DWAIT with squash pending.
    branchTaken = 1; IMem_Stall = 1; step();
    quiet(); DMem_Req = 1; DMem_Stall = 1; step(); step();
    quiet(); rst = 1; step();
    rst = 0;
    #2; chk("rst_dwait_en", {27'd0, PC_En, IFID_En, IDEX_En, EXMEM_En, MEMWB_En}, 32'h1F);
    step();
`ifdef STALL_CNT_EN
    chk("rst_cnt", {16'd0, stallCount}, 0);
`endif
    IMem_Done = 1;
    #2; chk("rst_sq", IFID_Flush, 0);
    step();

    // Randomized traffic.
    for (int n = 0; n < 4000; n++) begin
      rst            = m_halted ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 59) == 0);
      MEMWB_Halt     = ($urandom_range(0, 149) == 0);
      IDEX_MemRead   = $urandom_range(0, 1);
      IDEX_Rd        = 3'($urandom_range(0, 3));
      IFID_Rs        = 3'($urandom_range(0, 3));
      IFID_Rt        = 3'($urandom_range(0, 3));
      IFID_ReadingRs = $urandom_range(0, 1);
      IFID_ReadingRt = $urandom_range(0, 1);
      branchTaken    = ($urandom_range(0, 4) == 0);
      IMem_Stall     = $urandom_range(0, 1);
      IMem_Done      = ($urandom_range(0, 2) == 0);
      DMem_Req       = $urandom_range(0, 1);
      DMem_Stall     = $urandom_range(0, 1);
      DMem_Done      = ($urandom_range(0, 2) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
